// File: rtl/stream_burst_writer.sv
// stream_burst_writer
//   Collects words into a small burst buffer, then on a start request
//   streams the whole burst into a downstream fifo with valid/ready
//   handshaking, one word per cycle when the fifo keeps up.
//
// Ports
//   clk               single clock, all state changes on its rising edge
//   rst               asynchronous active-low reset
//   load_valid/data   word offered to the burst buffer
//   load_ready        buffer can take a word (idle and not full)
//   start             one-cycle request to send the buffered burst
//   fifo_in_data      registered word to the downstream fifo
//   fifo_write_valid  registered valid to the downstream fifo
//   fifo_write_ready  downstream fifo can accept this cycle
//   busy              high while a burst is sending or completing
//   done              one-cycle pulse when a burst completes
//   words_sent        words accepted by the fifo since reset (wraps)

module stream_burst_writer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             start,
    output logic [WIDTH-1:0] fifo_in_data,
    output logic             fifo_write_valid,
    input  logic             fifo_write_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      words_sent
);

    // Buffer address width, plus one extra bit so count can reach DEPTH.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [CW-1:0]   idx;
    logic [CW-1:0]   len;
    logic [WIDTH-1:0] buf_mem [DEPTH];

    logic            load_fire;
    logic [CW-1:0]   burst_len;
    logic [CW-1:0]   idx_nxt;
    logic            xfer;
    logic            last_xfer;

    assign load_ready = (state == IDLE) && (count < DEPTH_C);
    assign load_fire  = load_valid && load_ready;

    // A word accepted in the same cycle as start joins this burst.
    assign burst_len  = count + CW'(load_fire);

    assign idx_nxt    = idx + CW'(1);
    assign xfer       = fifo_write_valid && fifo_write_ready;
    assign last_xfer  = (idx == len - CW'(1));

    // Buffer storage carries no reset: entries are only read after being
    // written in the current fill, so stale contents never reach the fifo.
    always_ff @(posedge clk) begin
        if (load_fire)
            buf_mem[count[AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            count            <= '0;
            idx              <= '0;
            len              <= '0;
            words_sent       <= '0;
            fifo_write_valid <= 1'b0;
            fifo_in_data     <= '0;
            done             <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_fire)
                        count <= count + CW'(1);
                    if (start) begin
                        busy <= 1'b1;
                        idx  <= '0;
                        len  <= burst_len;
                        if (burst_len != '0) begin
                            state            <= SEND;
                            fifo_write_valid <= 1'b1;
                            // Word 0 is still on load_data when the buffer
                            // was empty and this cycle's load starts the burst.
                            fifo_in_data     <= (count == '0) ? load_data : buf_mem[0];
                        end else begin
                            // Nothing to send: complete without a fifo write.
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    // Valid stays high until the last word is accepted, so
                    // backpressure only stalls, never withdraws, a word.
                    if (xfer) begin
                        words_sent <= words_sent + 16'd1;
                        idx        <= idx_nxt;
                        if (last_xfer) begin
                            fifo_write_valid <= 1'b0;
                            state            <= DONE;
                            done             <= 1'b1;
                        end else begin
                            fifo_in_data <= buf_mem[idx_nxt[AW-1:0]];
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
